// File: rtl/jpeg_bit_window.sv
// jpeg_bit_window
// Byte-to-bit front end for the JPEG decoder. It takes the compressed file
// one byte per cycle and removes 0xFF00 byte stuffing while the decoder is in
// entropy-coded data. It presents a left-aligned 64-bit look-ahead window,
// and the consumer may discard 0..64 leading bits per cycle.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   clr           soft clear, same effect as rst
//   in_data       next file byte
//   in_valid      in_data is valid
//   in_last       in_data is the final byte of the file
//   in_ready      byte is accepted this cycle (state only, independent of eat)
//   destuff_en    enables 0xFF00 removal (entropy-coded segment)
//   eat, eat_len  consume eat_len (0..64, larger values clamp to 64) leading bits
//   bit_avali     bit_out is valid for decision and consumption
//   bit_out       next 64 stream bits, MSB = oldest
//   bit_cnt       number of valid bits buffered
//   draining      in_last has been accepted; no more input is taken
//
// BUF_W must be >= 72 and a multiple of 8. It must also be <= 248 so that
// bit_cnt fits in 8 bits.
module jpeg_bit_window #(
    parameter int BUF_W = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_last,
    input  logic        destuff_en,
    input  logic        eat,
    input  logic [6:0]  eat_len,
    output logic        bit_avali,
    output logic [63:0] bit_out,
    output logic [7:0]  bit_cnt,
    output logic        draining
);

    localparam logic [7:0] READY_MAX = 8'(BUF_W - 8);

    // Bit count after consuming b bits, floored at zero. Underflow can only
    // happen in drain mode, where the consumer may eat past the end.
    function automatic logic [7:0] sat0(input logic [7:0] a, input logic [6:0] b);
        logic signed [9:0] diff;
        diff = $signed({2'b00, a}) - $signed({3'b000, b});
        return (diff < 0) ? 8'd0 : diff[7:0];
    endfunction

    function automatic logic [6:0] clamp_len(input logic [6:0] len);
        return (len > 7'd64) ? 7'd64 : len;
    endfunction

    logic [BUF_W-1:0] buffer;
    logic             ff_seen;

    logic             consume;
    logic             accept;
    logic             drop;
    logic             append;
    logic [6:0]       shift;
    logic [7:0]       base;
    logic [BUF_W-1:0] shifted;
    logic [BUF_W-1:0] placed;
    logic [BUF_W-1:0] buf_next;
    logic [7:0]       cnt_next;

    assign in_ready  = !draining && (bit_cnt <= READY_MAX);
    assign bit_avali = (bit_cnt >= 8'd64) || (draining && (bit_cnt != 8'd0));
    assign bit_out   = buffer[BUF_W-1 -: 64];

    assign consume = eat && bit_avali;
    assign accept  = in_valid && in_ready;
    // A 0x00 directly after an appended 0xFF in scan data is stuffing.
    assign drop    = accept && destuff_en && ff_seen && (in_data == 8'h00);
    assign append  = accept && !drop;

    // The consume is applied first. The new byte then lands right after the
    // last bit that survives the shift.
    always_comb begin
        shift    = consume ? clamp_len(eat_len) : 7'd0;
        base     = sat0(bit_cnt, shift);
        shifted  = buffer << shift;
        placed   = {in_data, {(BUF_W-8){1'b0}}} >> base;
        buf_next = shifted;
        cnt_next = base;
        if (append) begin
            buf_next = shifted | placed;
            cnt_next = base + 8'd8;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            buffer   <= '0;
            bit_cnt  <= 8'd0;
            draining <= 1'b0;
            ff_seen  <= 1'b0;
        end else begin
            buffer  <= buf_next;
            bit_cnt <= cnt_next;
            if (append)
                ff_seen <= (in_data == 8'hFF);
            else if (drop)
                ff_seen <= 1'b0;
            if (accept && in_last)
                draining <= 1'b1;
        end
    end

endmodule

// File: tb/tb_jpeg_bit_window.sv
module tb_jpeg_bit_window;

    localparam int BUF_W = 128;

    logic        clk = 1'b0;
    logic        rst, clr;
    logic [7:0]  in_data;
    logic        in_valid, in_ready, in_last, destuff_en;
    logic        eat;
    logic [6:0]  eat_len;
    logic        bit_avali;
    logic [63:0] bit_out;
    logic [7:0]  bit_cnt;
    logic        draining;

    jpeg_bit_window #(.BUF_W(BUF_W)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .destuff_en(destuff_en),
        .eat(eat), .eat_len(eat_len),
        .bit_avali(bit_avali), .bit_out(bit_out), .bit_cnt(bit_cnt),
        .draining(draining)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    // Reference model: the stream is a plain queue of bits, oldest first.
    bit mq[$];
    bit m_drn = 1'b0;
    bit m_ff  = 1'b0;

    function automatic int m_cnt();
        return mq.size();
    endfunction

    function automatic logic [63:0] m_out();
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 64; i++)
            if (i < mq.size()) w[63-i] = mq[i];
        return w;
    endfunction

    function automatic logic m_avali();
        return (mq.size() >= 64) || (m_drn && mq.size() != 0);
    endfunction

    function automatic logic m_ready();
        return !m_drn && (mq.size() <= BUF_W - 8);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model update on each active edge, from the pre-edge state and inputs.
    initial forever begin
        @(posedge clk);
        if (rst || clr) begin
            mq.delete();
            m_drn = 1'b0;
            m_ff  = 1'b0;
        end else begin
            bit av, rd;
            av = m_avali();
            rd = m_ready();
            if (eat && av) begin
                int n;
                n = (eat_len > 7'd64) ? 64 : int'(eat_len);
                for (int k = 0; k < n; k++)
                    if (mq.size() > 0) void'(mq.pop_front());
            end
            if (in_valid && rd) begin
                if (destuff_en && m_ff && in_data == 8'h00) begin
                    m_ff = 1'b0;
                end else begin
                    for (int k = 7; k >= 0; k--) mq.push_back(in_data[k]);
                    m_ff = (in_data == 8'hFF);
                end
                if (in_last) m_drn = 1'b1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("cyc_bit_cnt",   64'(bit_cnt),   64'(m_cnt()));
            chk("cyc_bit_out",   bit_out,        m_out());
            chk("cyc_bit_avali", 64'(bit_avali), 64'(m_avali()));
            chk("cyc_in_ready",  64'(in_ready),  64'(m_ready()));
            chk("cyc_draining",  64'(draining),  64'(m_drn));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input logic last);
        in_data  = b;
        in_valid = 1'b1;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_eat(input logic [6:0] n);
        eat     = 1'b1;
        eat_len = n;
        step();
        eat     = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    logic [7:0] hdr [8]  = '{8'hFF, 8'hD8, 8'hFF, 8'hDB, 8'h00, 8'h43, 8'h00, 8'h01};
    logic [7:0] scan[10] = '{8'h12, 8'hFF, 8'h00, 8'h34, 8'hFF, 8'h00, 8'h56, 8'h78, 8'h9A, 8'hBC};

    initial begin
        rst = 1'b1; clr = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
        destuff_en = 1'b0; eat = 1'b0; eat_len = 7'd0;
        step();
        chk_on = 1'b1;
        step();
        chk("rst_bit_cnt",  64'(bit_cnt),   64'd0);
        chk("rst_avali",    64'(bit_avali), 64'd0);
        chk("rst_ready",    64'(in_ready),  64'd1);
        chk("rst_bit_out",  bit_out,        64'd0);
        chk("rst_draining", 64'(draining),  64'd0);
        rst = 1'b0;

        // Header bytes, no destuffing.
        for (int i = 0; i < 8; i++) begin
            chk("hdr_avali_low", 64'(bit_avali), 64'd0);
            push(hdr[i], 1'b0);
        end
        chk("hdr_bit_out",   bit_out,        64'hFFD8FFDB00430001);
        chk("hdr_model_out", m_out(),        64'hFFD8FFDB00430001);
        chk("hdr_bit_cnt",   64'(bit_cnt),   64'd64);
        chk("hdr_avali",     64'(bit_avali), 64'd1);

        // Scan data with stuffing removal.
        do_clr();
        destuff_en = 1'b1;
        for (int i = 0; i < 10; i++) push(scan[i], 1'b0);
        chk("scan_bit_out",   bit_out,      64'h12FF34FF56789ABC);
        chk("scan_model_out", m_out(),      64'h12FF34FF56789ABC);
        chk("scan_bit_cnt",   64'(bit_cnt), 64'd64);
        destuff_en = 1'b0;

        // Full buffer and back-pressure.
        do_clr();
        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i), 1'b0);
        chk("full_cnt",   64'(bit_cnt),  64'd128);
        chk("full_ready", 64'(in_ready), 64'd0);
        in_data = 8'h77; in_valid = 1'b1;
        do_eat(7'd3);
        chk("full_eat3_cnt",   64'(bit_cnt),  64'd125);
        chk("full_eat3_ready", 64'(in_ready), 64'd0);
        eat = 1'b1; eat_len = 7'd5;
        step();
        eat = 1'b0; in_valid = 1'b0;
        chk("full_eat5_cnt",   64'(bit_cnt),  64'd120);
        chk("full_eat5_ready", 64'(in_ready), 64'd1);
        chk("full_eat5_out",   bit_out,       64'h1112131415161718);

        // Simultaneous consume and append.
        do_clr();
        for (int i = 0; i < 8; i++) push(8'h30 + 8'(i), 1'b0);
        in_data = 8'hA5; in_valid = 1'b1; eat = 1'b1; eat_len = 7'd13;
        step();
        in_valid = 1'b0; eat = 1'b0;
        chk("sim_cnt",   64'(bit_cnt),   64'd59);
        chk("sim_byte",  64'(bit_out[12:5]), 64'hA5);
        chk("sim_avali", 64'(bit_avali), 64'd0);

        // Drain.
        do_clr();
        for (int i = 0; i < 5; i++) push(8'h50 + 8'(i), 1'b0);
        push(8'hEE, 1'b1);
        chk("drn_cnt",   64'(bit_cnt),   64'd48);
        chk("drn_flag",  64'(draining),  64'd1);
        chk("drn_avali", 64'(bit_avali), 64'd1);
        chk("drn_ready", 64'(in_ready),  64'd0);
        chk("drn_out",   bit_out,        64'h5051525354EE0000);
        do_eat(7'd48);
        chk("drn_eat_avali", 64'(bit_avali), 64'd0);
        chk("drn_eat_cnt",   64'(bit_cnt),   64'd0);
        do_eat(7'd10);
        chk("drn_ign_cnt",   64'(bit_cnt),   64'd0);
        chk("drn_ign_ready", 64'(in_ready),  64'd0);

        // Clear mid-stream forgets ff_seen.
        do_clr();
        for (int i = 0; i < 12; i++) push(8'h01 + 8'(i), 1'b0);
        push(8'hFF, 1'b0);
        do_eat(7'd4);
        chk("clr_pre_cnt", 64'(bit_cnt), 64'd100);
        do_clr();
        destuff_en = 1'b1;
        push(8'h00, 1'b0);
        chk("clr_cnt", 64'(bit_cnt), 64'd8);
        chk("clr_out", bit_out,      64'h0);
        destuff_en = 1'b0;

        // Randomized traffic, checked every cycle by the compare process.
        for (int c = 0; c < 4000; c++) begin
            case ($urandom_range(0, 3))
                0: in_data = 8'hFF;
                1: in_data = 8'h00;
                default: in_data = 8'($urandom);
            endcase
            in_valid   = ($urandom_range(0, 3) != 0);
            in_last    = ($urandom_range(0, 199) == 0);
            destuff_en = ($urandom_range(0, 3) != 0);
            eat        = ($urandom_range(0, 1) == 1);
            eat_len    = 7'($urandom_range(0, 80));
            clr        = ($urandom_range(0, 99) == 0);
            step();
        end
        in_valid = 1'b0; eat = 1'b0; clr = 1'b0; in_last = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
